apbm_spi_sclk_ctrl: RTL and testbench

//  Sequences the SPI serial clock for the APB-master SPI IP. It is fed by the clock-tree root buffer.
//  It divides clk to generate sclk and frames each transfer with cs_n setup and hold.
//  It emits one-cycle sample/shift strobes to the shift-register datapath per CPOL/CPHA.

---
 rtl/apbm_spi_sclk_pkg.sv | 13 +
 rtl/apbm_spi_sclk_div.sv | 16 +
 rtl/apbm_spi_sclk_ctrl.sv | 100 ++++++++++
 tb/tb_apbm_spi_sclk_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/apbm_spi_sclk_pkg.sv
// apbm_spi_sclk_pkg: shared FSM state encoding and SPI mode constants for the sclk sequencer
package apbm_spi_sclk_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/apbm_spi_sclk_div.sv
// apbm_spi_sclk_div: half-period counter emitting one tick every div+1 enabled cycles
module apbm_spi_sclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == div;
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/apbm_spi_sclk_ctrl.sv
// apbm_spi_sclk_ctrl: SPI sclk sequencer with cs_n framing, CPOL/CPHA strobes, start/done/abort
module apbm_spi_sclk_ctrl
  import apbm_spi_sclk_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [CNT_W-1:0] cfg_nbits,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic             sample_stb,
  output logic             shift_stb
);
  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic             cpol_q, cpha_q;
  logic [CNT_W-1:0] nbits_q;
  logic [CNT_W:0]   ecnt;
  logic             tick, go, lead, last;
  assign go   = state == ST_IDLE && start;
  assign lead = !ecnt[0];
  assign last = ecnt == {nbits_q, 1'b1};
  apbm_spi_sclk_div #(.DIV_W(DIV_W)) u_div (
    .clk (clk),
    .rst (rst),
    .clr (go),
    .en  (state != ST_IDLE),
    .div (div_q),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      nbits_q    <= '0;
      ecnt       <= '0;
    end else if (state != ST_IDLE && abort) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= cpol_q;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
    end else begin
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk <= cfg_cpol;
          if (start) begin
            state   <= ST_SETUP;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            div_q   <= cfg_div;
            cpol_q  <= cfg_cpol;
            cpha_q  <= cfg_cpha;
            nbits_q <= cfg_nbits;
            ecnt    <= '0;
          end
        end
        ST_SETUP, ST_XFER: begin
          if (tick) begin
            sclk       <= ~sclk;
            ecnt       <= last ? ecnt : ecnt + 1'b1;
            sample_stb <= cpha_q ? !lead : lead;
            shift_stb  <= cpha_q ? lead : !lead && !last;
            state      <= last ? ST_HOLD : ST_XFER;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cs_n  <= 1'b1;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apbm_spi_sclk_ctrl.sv
// tb_apbm_spi_sclk_ctrl: directed self-checking bench for the SPI sclk sequencer
module tb_apbm_spi_sclk_ctrl;
  import apbm_spi_sclk_pkg::*;
  logic       clk = 1'b0, rst = 1'b1, cfg_cpol = 1'b0, cfg_cpha = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [5:0] cfg_nbits = '0;
  logic       busy, done, cs_n, sclk, sample_stb, shift_stb;
  int         n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  apbm_spi_sclk_ctrl #(.DIV_W(8), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .cfg_cpol  (cfg_cpol),
    .cfg_cpha  (cfg_cpha),
    .cfg_nbits (cfg_nbits),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .sample_stb(sample_stb),
    .shift_stb (shift_stb)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [5:0] obs();
    return {cs_n, busy, sclk, sample_stb, shift_stb, done};
  endfunction
  function automatic logic [5:0] exp_vec(int c, bit cpol, bit cpha, int d, int b);
    int  dc, e, k;
    bit  in_x;
    dc   = 1 + (2 * b + 1) * d;
    e    = (c - 1) / d;
    if (e > 2 * b) e = 2 * b;
    k    = ((c - 1) % d == 0 && (c - 1) / d >= 1 && (c - 1) / d <= 2 * b) ? (c - 1) / d : 0;
    in_x = c >= 1 && c < dc;
    return {!in_x, in_x, cpol ^ e[0],
            k != 0 && ((k % 2 == 1) != cpha),
            k != 0 && (cpha ? (k % 2 == 1) : (k % 2 == 0 && k != 2 * b)),
            c == dc};
  endfunction
  task automatic test_reset();
    bit saw_done;
    rst = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (obs() !== 6'b100000) begin n_bad++; $display("FAIL reset_init got %b exp %b", obs(), 6'b100000); end
    rst = 1'b0;
    cfg_div = 8'($urandom_range(0, 3));
    cfg_nbits = 6'($urandom_range(0, 15));
    {cfg_cpol, cfg_cpha} = 2'($urandom_range(0, 3));
    start = 1'b1;
    step();
    start = 1'b0;
    repeat ($urandom_range(3, 20)) step();
    rst = 1'b1;
    cfg_cpol = 1'b0;
    cfg_cpha = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (obs() !== 6'b100000) begin n_bad++; $display("FAIL reset_mid got %b exp %b", obs(), 6'b100000); end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0 || obs() !== 6'b100000) begin
      n_bad++; $display("FAIL reset_after done_seen %b got %b exp %b", saw_done, obs(), 6'b100000);
    end
  endtask
  task automatic test_mode0();
    int ns = 0, nf = 0;
    {cfg_cpol, cfg_cpha} = MODE0;
    cfg_div = 8'd0;
    cfg_nbits = 6'd7;
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_vec(c, 0, 0, 1, 8)) begin
        n_bad++; $display("FAIL mode0 c=%0d got %b exp %b", c, obs(), exp_vec(c, 0, 0, 1, 8));
      end
      if (sample_stb) ns++;
      if (shift_stb) nf++;
    end
    n_cmp++;
    if (ns != 8 || nf != 7) begin n_bad++; $display("FAIL mode0_counts got %0d/%0d exp 8/7", ns, nf); end
  endtask
  task automatic test_mode3();
    {cfg_cpol, cfg_cpha} = MODE3;
    cfg_div = 8'd3;
    cfg_nbits = 6'd0;
    repeat (2) step();
    n_cmp++;
    if (sclk !== 1'b1) begin n_bad++; $display("FAIL mode3_idle got %b exp 1", sclk); end
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_vec(c, 1, 1, 4, 1)) begin
        n_bad++; $display("FAIL mode3 c=%0d got %b exp %b", c, obs(), exp_vec(c, 1, 1, 4, 1));
      end
    end
    {cfg_cpol, cfg_cpha} = MODE0;
    repeat (2) step();
  endtask
  task automatic test_cfg_change();
    int nd = 0;
    {cfg_cpol, cfg_cpha} = MODE0;
    cfg_div = 8'd0;
    cfg_nbits = 6'd7;
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(c, 0, 0, 1, 8)) begin
        n_bad++; $display("FAIL cfg_change c=%0d got %b exp %b", c, obs(), exp_vec(c, 0, 0, 1, 8));
      end
      if (done) nd++;
      start = (c >= 2 && c <= 15) ? c[0] : 1'b0;
      if (c == 3) begin cfg_div = 8'd5; cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_nbits = 6'd2; end
      if (c == 16) begin cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_nbits = 6'd7; end
    end
    n_cmp++;
    if (nd != 1) begin n_bad++; $display("FAIL cfg_change_done got %0d exp 1", nd); end
  endtask
  task automatic test_abort();
    logic [5:0] e;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 1) start = 1'b0;
      e = c <= 10 ? exp_vec(c, 0, 0, 1, 8) : 6'b100000;
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL abort c=%0d got %b exp %b", c, obs(), e); end
      abort = c == 10;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({cs_n, busy} !== 2'b10) begin n_bad++; $display("FAIL abort_idle got %b exp 10", {cs_n, busy}); end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    n_cmp++;
    if ({cs_n, busy} !== 2'b01) begin n_bad++; $display("FAIL abort_start_idle got %b exp 01", {cs_n, busy}); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (obs() !== 6'b100000) begin n_bad++; $display("FAIL abort_busy got %b exp %b", obs(), 6'b100000); end
    step();
  endtask
  task automatic test_back_to_back();
    logic [5:0] e;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      e = c <= 18 ? exp_vec(c, 0, 0, 1, 8) : exp_vec(c - 18, 0, 0, 1, 8);
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL back_to_back c=%0d got %b exp %b", c, obs(), e); end
      if (c == 19) start = 1'b0;
    end
  endtask
  task automatic test_edge_bound();
    int   ne = 0, ns = 0, nf = 0;
    logic prev;
    cfg_nbits = 6'd63;
    prev = sclk;
    start = 1'b1;
    for (int c = 1; c <= 135; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_vec(c, 0, 0, 1, 64)) begin
        n_bad++; $display("FAIL edge_bound c=%0d got %b exp %b", c, obs(), exp_vec(c, 0, 0, 1, 64));
      end
      if (sclk !== prev) ne++;
      prev = sclk;
      if (sample_stb) ns++;
      if (shift_stb) nf++;
    end
    n_cmp++;
    if (ne != 128 || ns != 64 || nf != 63) begin
      n_bad++; $display("FAIL edge_bound_counts got %0d/%0d/%0d exp 128/64/63", ne, ns, nf);
    end
  endtask
  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_cfg_change();
    test_abort();
    test_back_to_back();
    test_edge_bound();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
